// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/response and SPI pin bundle for spi_master_ctrl
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  tx_valid, tx_data, miso,
    output tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_valid, tx_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: one word per request, MSB first, full duplex
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  spi_master_ctrl_if.master spi
);
  localparam int DIV_W     = $clog2(CLK_DIV + 1);
  localparam int EDGE_W    = $clog2(2 * DATA_WIDTH);
  localparam int LAST_EDGE = 2 * DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DIV_W-1:0]      r_div;
  logic [EDGE_W-1:0]     r_edge;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_mosi;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_accept;
  logic [EDGE_W-1:0]     w_edge_nxt;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_sample;
  logic                  w_drive;
  logic                  w_tx_ready;
  logic                  w_busy;
  logic                  w_cs_n;
  logic                  w_sclk;

  assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last     = (r_edge == EDGE_W'(LAST_EDGE));
  assign w_accept   = (r_state == IDLE) && spi.tx_valid;
  assign w_edge_nxt = r_edge + 1'b1;

  // Leading edge: entering an even half-period (the first one is the SETUP exit).
  assign w_lead   = (r_state == SETUP && w_tick) ||
                    (r_state == XFER && w_tick && !w_last && !w_edge_nxt[0]);
  assign w_trail  = (r_state == XFER) && w_tick && !w_last && w_edge_nxt[0];
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_drive  = CPHA ? w_lead : (w_trail && (w_edge_nxt != EDGE_W'(LAST_EDGE)));

  always_comb begin
    w_next     = r_state;
    w_tx_ready = 1'b0;
    w_busy     = 1'b1;
    w_cs_n     = 1'b0;
    w_sclk     = CPOL;
    case (r_state)
      IDLE: begin
        w_tx_ready = 1'b1;
        w_busy     = 1'b0;
        w_cs_n     = 1'b1;
        if (spi.tx_valid) w_next = SETUP;
      end
      SETUP: if (w_tick) w_next = XFER;
      XFER: begin
        w_sclk = CPOL ^ ~r_edge[0];
        if (w_tick && w_last) w_next = HOLD;
      end
      HOLD: if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_edge     <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == IDLE || w_tick) r_div <= '0;
      else                           r_div <= r_div + 1'b1;

      if (r_state != XFER)                    r_edge <= '0;
      else if (w_tick && !w_last)             r_edge <= w_edge_nxt;

      // One register serves both directions: bits leave at the MSB, miso enters at the LSB.
      if (w_accept)      r_shift <= spi.tx_data;
      else if (w_sample) r_shift <= {r_shift[DATA_WIDTH-2:0], spi.miso};

      if (w_accept && !CPHA) r_mosi <= spi.tx_data[DATA_WIDTH-1];
      else if (w_drive)      r_mosi <= r_shift[DATA_WIDTH-1];

      r_rx_valid <= (r_state == HOLD) && w_tick;
      if ((r_state == HOLD) && w_tick) r_rx_data <= r_shift;
    end
  end

  assign spi.tx_ready = w_tx_ready;
  assign spi.busy     = w_busy;
  assign spi.cs_n     = w_cs_n;
  assign spi.sclk     = w_sclk;
  assign spi.mosi     = r_mosi;
  assign spi.rx_valid = r_rx_valid;
  assign spi.rx_data  = r_rx_data;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl in mode 0 and mode 3
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_WIDTH(8)) bus0 ();
  spi_master_ctrl_if #(.DATA_WIDTH(8)) bus1 ();

  logic miso0_tb;
  bit   loop0;
  assign bus0.miso = loop0 ? bus0.mosi : miso0_tb;
  assign bus1.miso = bus1.mosi;

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .spi(bus0));
  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .spi(bus1));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         acc_q[$];
  int         got_cyc_q[$];
  logic [7:0] mosi_rise;
  int         n_rise, n_sclk_hi, cs_hi_cnt, bad_spacing;

  // Drives one or two words into dut0 and records everything it produces, cycle by cycle.
  task automatic run0(input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                      input logic [7:0] slave, input bit lp, input int max_cyc);
    int idx, last_acc, last_rise;
    logic prev_sclk;
    exp_q.delete(); got_q.delete(); acc_q.delete(); got_cyc_q.delete();
    mosi_rise = 8'h00; n_rise = 0; n_sclk_hi = 0; cs_hi_cnt = 0; bad_spacing = 0;
    loop0 = lp; idx = 0; last_acc = -10; last_rise = -1;
    miso0_tb = slave[7];
    @(negedge clk);
    prev_sclk = bus0.sclk;
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = w0;
    for (int c = 0; c < max_cyc; c++) begin
      if (bus0.rx_valid) begin
        got_q.push_back(bus0.rx_data);
        got_cyc_q.push_back(c);
      end
      if (c >= 1 && bus0.cs_n && got_q.size() < nwords) cs_hi_cnt++;
      if (bus0.sclk) n_sclk_hi++;
      if (!prev_sclk && bus0.sclk) begin
        if (last_rise >= 0 && c - last_rise != 8) bad_spacing++;
        last_rise = c;
        mosi_rise = {mosi_rise[6:0], bus0.mosi};
        n_rise++;
      end
      prev_sclk = bus0.sclk;
      miso0_tb = (n_rise < 8) ? slave[3'(7 - n_rise)] : 1'b0;
      if (bus0.tx_valid && bus0.tx_ready) begin
        exp_q.push_back(lp ? ((idx == 0) ? w0 : w1) : slave);
        acc_q.push_back(c);
        idx++;
        last_acc = c;
      end else if (c == last_acc + 1) begin
        if (idx < nwords) bus0.tx_data = w1;
        else begin
          bus0.tx_valid = 1'b0;
          bus0.tx_data  = ~bus0.tx_data;
        end
      end else if (nwords == 1 && c == 20) begin
        bus0.tx_valid = 1'b1;
        bus0.tx_data  = 8'h5A;
      end else if (nwords == 1 && c == 40) begin
        bus0.tx_valid = 1'b0;
      end
      if (got_q.size() == nwords && c >= got_cyc_q[$] + 2) break;
      @(negedge clk);
    end
    bus0.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic act[9];
    logic req[9];
    string nm[9];
    rst_n = 1'b0;
    bus0.tx_valid = 1'b0; bus0.tx_data = 8'h00;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00;
    loop0 = 1'b1; miso0_tb = 1'b0;
    repeat (3) @(negedge clk);
    act[0] = bus0.cs_n;          req[0] = 1'b1; nm[0] = "reset_cs_n";
    act[1] = bus0.sclk;          req[1] = 1'b0; nm[1] = "reset_sclk_cpol0";
    act[2] = bus0.tx_ready;      req[2] = 1'b1; nm[2] = "reset_tx_ready";
    act[3] = bus0.rx_valid;      req[3] = 1'b0; nm[3] = "reset_rx_valid";
    act[4] = bus0.busy;          req[4] = 1'b0; nm[4] = "reset_busy";
    act[5] = bus0.mosi;          req[5] = 1'b0; nm[5] = "reset_mosi";
    act[6] = |bus0.rx_data;      req[6] = 1'b0; nm[6] = "reset_rx_data";
    act[7] = bus1.sclk;          req[7] = 1'b1; nm[7] = "reset_sclk_cpol1";
    act[8] = bus1.cs_n;          req[8] = 1'b1; nm[8] = "reset_cs_n_mode3";
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (act[i] !== req[i]) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", nm[i], act[i], req[i]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loopback();
    logic [7:0] e, g;
    run0(8'hA5, 8'h00, 1, 8'h00, 1'b1, 120);
    n_vec++;
    if (got_q.size() !== 1) begin
      n_err++; $display("FAIL loop_rx_count: got %0d expected 1", got_q.size());
    end
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL loop_rx_data: got %h expected %h", g, e); end
      n_vec++;
      if (got_cyc_q[0] - acc_q[0] !== 73) begin
        n_err++; $display("FAIL loop_latency: got %0d expected 73", got_cyc_q[0] - acc_q[0]);
      end
    end
    n_vec++;
    if (n_rise !== 8) begin n_err++; $display("FAIL loop_rise_count: got %0d expected 8", n_rise); end
    n_vec++;
    if (mosi_rise !== 8'hA5) begin n_err++; $display("FAIL loop_mosi_bits: got %h expected a5", mosi_rise); end
    n_vec++;
    if (cs_hi_cnt !== 0) begin n_err++; $display("FAIL loop_cs_glitch: got %0d expected 0", cs_hi_cnt); end
    n_vec++;
    if (bad_spacing !== 0) begin n_err++; $display("FAIL loop_sclk_period: got %0d expected 0", bad_spacing); end
  endtask

  task automatic test_slave_pattern();
    logic [7:0] e, g;
    run0(8'hFF, 8'h00, 1, 8'h3C, 1'b0, 120);
    n_vec++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++; $display("FAIL slave_rx_count: got %0d expected 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL slave_rx_data: got %h expected %h", g, e); end
    end
    n_vec++;
    if (n_sclk_hi !== 32) begin n_err++; $display("FAIL slave_sclk_high: got %0d expected 32", n_sclk_hi); end
    n_vec++;
    if (bad_spacing !== 0) begin n_err++; $display("FAIL slave_sclk_period: got %0d expected 0", bad_spacing); end
    n_vec++;
    if (n_rise !== 8) begin n_err++; $display("FAIL slave_rise_count: got %0d expected 8", n_rise); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    run0(8'h01, 8'h80, 2, 8'h00, 1'b1, 250);
    n_vec++;
    if (got_q.size() !== 2) begin
      n_err++; $display("FAIL b2b_rx_count: got %0d expected 2", got_q.size());
    end else begin
      n_vec++;
      if (got_cyc_q[1] - got_cyc_q[0] !== 73) begin
        n_err++; $display("FAIL b2b_spacing: got %0d expected 73", got_cyc_q[1] - got_cyc_q[0]);
      end
      n_vec++;
      if (got_cyc_q[0] - acc_q[0] !== 73) begin
        n_err++; $display("FAIL b2b_latency: got %0d expected 73", got_cyc_q[0] - acc_q[0]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL b2b_rx_data: got %h expected %h", g, e); end
    end
    n_vec++;
    if (cs_hi_cnt !== 1) begin n_err++; $display("FAIL b2b_cs_high: got %0d expected 1", cs_hi_cnt); end
  endtask

  task automatic test_abort();
    int rx_seen = 0;
    logic [7:0] e, g;
    loop0 = 1'b1;
    @(negedge clk);
    bus0.tx_valid = 1'b1; bus0.tx_data = 8'h96;
    for (int c = 0; c < 30; c++) begin
      if (c == 1) bus0.tx_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b expected 1", bus0.busy); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus0.cs_n !== 1'b1) begin n_err++; $display("FAIL abort_cs_n: got %b expected 1", bus0.cs_n); end
    n_vec++;
    if (bus0.sclk !== 1'b0) begin n_err++; $display("FAIL abort_sclk: got %b expected 0", bus0.sclk); end
    n_vec++;
    if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus0.busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus0.rx_valid) rx_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus0.rx_valid) rx_seen++;
    end
    n_vec++;
    if (rx_seen !== 0) begin n_err++; $display("FAIL abort_no_rx: got %0d expected 0", rx_seen); end
    run0(8'h69, 8'h00, 1, 8'h00, 1'b1, 120);
    n_vec++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++; $display("FAIL abort_after_count: got %0d expected 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL abort_after_data: got %h expected %h", g, e); end
      n_vec++;
      if (got_cyc_q[0] - acc_q[0] !== 73) begin
        n_err++; $display("FAIL abort_after_latency: got %0d expected 73", got_cyc_q[0] - acc_q[0]);
      end
    end
  endtask

  task automatic test_mode3_clkdiv1();
    int lat = -1;
    int nr = 0;
    int bad = 0;
    logic [7:0] rxd = 8'h00;
    logic [7:0] mr = 8'h00;
    logic [7:0] e;
    logic ps, pm;
    @(negedge clk);
    n_vec++;
    if (bus1.sclk !== 1'b1) begin n_err++; $display("FAIL m3_idle_sclk: got %b expected 1", bus1.sclk); end
    exp_q.delete();
    ps = bus1.sclk; pm = bus1.mosi;
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'hC3;
    if (bus1.tx_ready) exp_q.push_back(8'hC3);
    for (int c = 0; c < 40; c++) begin
      if (c == 1) begin bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00; end
      if (bus1.rx_valid && lat < 0) begin lat = c; rxd = bus1.rx_data; end
      if (!ps && bus1.sclk) begin mr = {mr[6:0], bus1.mosi}; nr++; end
      if (bus1.mosi !== pm && !(ps && !bus1.sclk)) bad++;
      ps = bus1.sclk; pm = bus1.mosi;
      @(negedge clk);
    end
    n_vec++;
    if (lat !== 19) begin n_err++; $display("FAIL m3_latency: got %0d expected 19", lat); end
    n_vec++;
    if (exp_q.size() !== 1) begin
      n_err++; $display("FAIL m3_accept: got %0d expected 1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if (rxd !== e) begin n_err++; $display("FAIL m3_rx_data: got %h expected %h", rxd, e); end
    end
    n_vec++;
    if (mr !== 8'hC3) begin n_err++; $display("FAIL m3_mosi_bits: got %h expected c3", mr); end
    n_vec++;
    if (nr !== 8) begin n_err++; $display("FAIL m3_rise_count: got %0d expected 8", nr); end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL m3_mosi_on_fall: got %0d expected 0", bad); end
    n_vec++;
    if (bus1.sclk !== 1'b1) begin n_err++; $display("FAIL m3_end_sclk: got %b expected 1", bus1.sclk); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0_loopback();
    test_slave_pattern();
    test_back_to_back();
    test_abort();
    test_mode3_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
